// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and port-select encodings for the memory port arbiter.
package mem_arb_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_D  = 2'd2,
        DONE   = 2'd3
    } arb_state_t;
    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;
endpackage

// File: rtl/mem_arb_wait_timer.sv
// mem_arb_wait_timer: counts grant cycles without ack and flags a hung access.
module mem_arb_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_ack,
    output logic o_timeout
);
    localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear)
            r_cnt <= '0;
        else if (i_enable && !i_ack)
            r_cnt <= r_cnt + CW'(1);
    end
    // Fires in the cycle whose missing ack would bring the count to MAX_WAIT; an ack there wins.
    assign o_timeout = (MAX_WAIT != 0) && i_enable && !i_ack && (r_cnt == LAST);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one req/ack memory between fetch and data ports.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties instead of data-first.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_if_req,
    input  logic [ADDR_W-1:0]   i_if_addr,
    output logic [DATA_W-1:0]   o_if_rdata,
    output logic                o_if_valid,
    input  logic                i_d_req,
    input  logic                i_d_we,
    input  logic [ADDR_W-1:0]   i_d_addr,
    input  logic [DATA_W-1:0]   i_d_wdata,
    input  logic [DATA_W/8-1:0] i_d_be,
    output logic [DATA_W-1:0]   o_d_rdata,
    output logic                o_d_valid,
    output logic                o_m_req,
    output logic                o_m_we,
    output logic [ADDR_W-1:0]   o_m_addr,
    output logic [DATA_W-1:0]   o_m_wdata,
    output logic [DATA_W/8-1:0] o_m_be,
    input  logic                i_m_ack,
    input  logic [DATA_W-1:0]   i_m_rdata,
    output logic                o_stall,
    output logic                o_err
);
    arb_state_t          r_state;
    logic                r_m_req;
    logic                r_m_we;
    logic [ADDR_W-1:0]   r_m_addr;
    logic [DATA_W-1:0]   r_m_wdata;
    logic [DATA_W/8-1:0] r_m_be;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_d_rdata;
    logic                r_if_valid;
    logic                r_d_valid;
    logic                r_err;
    logic                w_pick_d;
    logic                w_in_gnt;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_rdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic r_last;
    assign w_pick_d = i_d_req && (!i_if_req || r_last == PORT_IF);
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_last <= PORT_IF;
        else if (r_state == IDLE && (i_d_req || i_if_req))
            r_last <= w_pick_d ? PORT_D : PORT_IF;
    end
`else
    assign w_pick_d = i_d_req;
`endif

    assign w_in_gnt = (r_state == GNT_IF) || (r_state == GNT_D);
    // Stores and timeouts return zero so stale bus data never reaches a port.
    assign w_rdata  = (i_m_ack && !r_m_we) ? i_m_rdata : '0;

    mem_arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (r_state == IDLE),
        .i_enable  (w_in_gnt),
        .i_ack     (i_m_ack),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_m_req    <= 1'b0;
            r_m_we     <= 1'b0;
            r_m_addr   <= '0;
            r_m_wdata  <= '0;
            r_m_be     <= '0;
            r_if_rdata <= '0;
            r_d_rdata  <= '0;
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_d_valid  <= 1'b0;
            r_err      <= 1'b0;
            case (r_state)
                IDLE: if (i_d_req || i_if_req) begin
                    r_state   <= w_pick_d ? GNT_D : GNT_IF;
                    r_m_req   <= 1'b1;
                    r_m_we    <= w_pick_d && i_d_we;
                    r_m_addr  <= w_pick_d ? i_d_addr : i_if_addr;
                    r_m_wdata <= w_pick_d ? i_d_wdata : '0;
                    r_m_be    <= w_pick_d ? i_d_be : '1;
                end
                GNT_IF, GNT_D: if (i_m_ack || w_timeout) begin
                    r_state <= DONE;
                    r_m_req <= 1'b0;
                    r_err   <= w_timeout;
                    if (r_state == GNT_D) begin
                        r_d_rdata <= w_rdata;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_if_rdata <= w_rdata;
                        r_if_valid <= 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_m_req    = r_m_req;
    assign o_m_we     = r_m_we;
    assign o_m_addr   = r_m_addr;
    assign o_m_wdata  = r_m_wdata;
    assign o_m_be     = r_m_be;
    assign o_if_rdata = r_if_rdata;
    assign o_if_valid = r_if_valid;
    assign o_d_rdata  = r_d_rdata;
    assign o_d_valid  = r_d_valid;
    assign o_err      = r_err;
    assign o_stall    = (i_if_req && !r_if_valid) || (i_d_req && !r_d_valid);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with MAX_WAIT=4.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    logic        m_ack = 1'b0;
    logic [31:0] m_rdata = 32'hDEADBEEF;
    logic        stall;
    logic        err;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    int m_cnt = 0;
    int req_cycles = 0;
    exp_t sb[$];
    logic [36:0] cmd_q[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .i_clk(clk), .i_reset(reset),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_valid(if_valid),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
        .o_d_rdata(d_rdata), .o_d_valid(d_valid),
        .o_m_req(m_req), .o_m_we(m_we), .o_m_addr(m_addr), .o_m_wdata(m_wdata), .o_m_be(m_be),
        .i_m_ack(m_ack), .i_m_rdata(m_rdata), .o_stall(stall), .o_err(err)
    );

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return a ^ 32'h00500093;
    endfunction

    // Memory model: acks after ack_delay grant cycles (-1 = never), logs each new command.
    always @(posedge clk) begin
        #1;
        if (m_req) begin
            if (m_cnt == 0) cmd_q.push_back({m_we, m_be, m_addr});
            m_ack = (m_cnt == ack_delay);
            m_rdata = m_ack ? mem_val(m_addr) : 32'hDEADBEEF;
            m_cnt++;
            req_cycles++;
        end else begin
            m_ack = 1'b0;
            m_rdata = 32'hDEADBEEF;
            m_cnt = 0;
        end
    end

    task automatic get_done(output logic got, output exp_t obs, output exp_t exp, output int cyc, output int nostall);
        got = 1'b0;
        cyc = 0;
        nostall = 0;
        obs = '0;
        exp = 'x;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (if_valid || d_valid) begin
                got = 1'b1;
                obs = '{d_valid, d_valid ? d_rdata : if_rdata, err};
                if (sb.size() > 0) exp = sb.pop_front();
            end else if (!stall) nostall++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({m_req, if_valid, d_valid, err, stall} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 00000", {m_req, if_valid, d_valid, err, stall});
        end
        checks++;
        if ({if_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", {if_rdata, d_rdata});
        end
        checks++;
        if ({m_we, m_be, m_addr, m_wdata} !== 69'h0) begin
            errors++;
            $display("FAIL reset_cmd: got %h expected 0", {m_we, m_be, m_addr, m_wdata});
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch();
        logic got;
        exp_t obs, exp;
        int cyc, ns;
        ack_delay = 0;
        req_cycles = 0;
        if_req = 1'b1;
        if_addr = 32'h0;
        sb.push_back('{PORT_IF, 32'h00500093, 1'b0});
        get_done(got, obs, exp, cyc, ns);
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("FAIL fetch_data: got %h (done=%0d) expected %h", obs, got, exp);
        end
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL fetch_latency: got %0d expected 2", cyc);
        end
        checks++;
        if (req_cycles != 1) begin
            errors++;
            $display("FAIL fetch_req_cycles: got %0d expected 1", req_cycles);
        end
        checks++;
        if (stall !== 1'b0 || ns != 0) begin
            errors++;
            $display("FAIL fetch_stall: got stall=%b early_low=%0d expected 0/0", stall, ns);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        logic got;
        exp_t obs, exp;
        int cyc, ns;
        cmd_q.delete();
        ack_delay = 2;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hCAFEF00D; d_be = 4'h3;
        if_req = 1'b1; if_addr = 32'h200;
        sb.push_back('{PORT_D, 32'h0, 1'b0});
        sb.push_back('{PORT_IF, mem_val(32'h200), 1'b0});
        get_done(got, obs, exp, cyc, ns);
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("FAIL sim_store: got %h (done=%0d) expected %h", obs, got, exp);
        end
        checks++;
        if (ns != 0 || stall !== 1'b1) begin
            errors++;
            $display("FAIL sim_stall_store: got early_low=%0d stall=%b expected 0/1", ns, stall);
        end
        d_req = 1'b0; d_we = 1'b0;
        get_done(got, obs, exp, cyc, ns);
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("FAIL sim_fetch: got %h (done=%0d) expected %h", obs, got, exp);
        end
        checks++;
        if (ns != 0) begin
            errors++;
            $display("FAIL sim_stall_fetch: got %0d low cycles expected 0", ns);
        end
        if_req = 1'b0;
        checks++;
        if (cmd_q.size() != 2 || cmd_q[0] !== {1'b1, 4'h3, 32'h100}) begin
            errors++;
            $display("FAIL sim_cmd_store: got %0d cmds first %h expected %h", cmd_q.size(), cmd_q.size() > 0 ? cmd_q[0] : 37'h0, {1'b1, 4'h3, 32'h100});
        end
        checks++;
        if (cmd_q.size() != 2 || cmd_q[1] !== {1'b0, 4'hf, 32'h200}) begin
            errors++;
            $display("FAIL sim_cmd_fetch: got %0d cmds second %h expected %h", cmd_q.size(), cmd_q.size() > 1 ? cmd_q[1] : 37'h0, {1'b0, 4'hf, 32'h200});
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_priority();
        logic got;
        exp_t obs, exp;
        int cyc, ns;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        ack_delay = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
        if_req = 1'b1; if_addr = 32'h400;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            if (k % 2 == 0) sb.push_back('{PORT_D, mem_val(32'h300), 1'b0});
            else sb.push_back('{PORT_IF, mem_val(32'h400), 1'b0});
`else
            sb.push_back('{PORT_D, mem_val(32'h300), 1'b0});
`endif
        end
        for (int k = 0; k < 4; k++) begin
            get_done(got, obs, exp, cyc, ns);
            checks++;
            if (!got || obs !== exp) begin
                errors++;
                $display("FAIL prio_grant%0d: got %h (done=%0d) expected %h", k, obs, got, exp);
            end
        end
        d_req = 1'b0;
        if_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic got;
        exp_t obs, exp;
        int cyc, ns;
        ack_delay = -1;
        req_cycles = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        sb.push_back('{PORT_D, 32'h0, 1'b1});
        get_done(got, obs, exp, cyc, ns);
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("FAIL timeout_data: got %h (done=%0d) expected %h", obs, got, exp);
        end
        checks++;
        if (req_cycles != 4 || cyc != 5) begin
            errors++;
            $display("FAIL timeout_len: got req=%0d lat=%0d expected 4/5", req_cycles, cyc);
        end
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_req, d_valid, if_valid, err} !== 4'b0) begin
            errors++;
            $display("FAIL timeout_idle: got %b expected 0000", {m_req, d_valid, if_valid, err});
        end
        @(negedge clk);
    endtask

    task automatic test_ack_at_limit();
        logic got;
        exp_t obs, exp;
        int cyc, ns;
        ack_delay = 3;
        req_cycles = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h44;
        sb.push_back('{PORT_D, mem_val(32'h44), 1'b0});
        get_done(got, obs, exp, cyc, ns);
        checks++;
        if (!got || obs !== exp) begin
            errors++;
            $display("FAIL limit_data: got %h (done=%0d) expected %h", obs, got, exp);
        end
        checks++;
        if (req_cycles != 4 || cyc != 5) begin
            errors++;
            $display("FAIL limit_len: got req=%0d lat=%0d expected 4/5", req_cycles, cyc);
        end
        d_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic got;
        exp_t obs, exp;
        int cyc, ns;
        ack_delay = -1;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80;
        repeat (2) @(negedge clk);
        checks++;
        if (m_req !== 1'b1) begin
            errors++;
            $display("FAIL mid_granted: got m_req=%b expected 1", m_req);
        end
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({m_req, d_valid, if_valid, err} !== 4'b0 || d_rdata !== 32'h0 || m_addr !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got ctl=%b rdata=%h addr=%h expected 0", {m_req, d_valid, if_valid, err}, d_rdata, m_addr);
        end
        reset = 1'b0;
        ack_delay = 0;
        if_req = 1'b1; if_addr = 32'h8;
        sb.push_back('{PORT_IF, mem_val(32'h8), 1'b0});
        get_done(got, obs, exp, cyc, ns);
        checks++;
        if (!got || obs !== exp || cyc != 2) begin
            errors++;
            $display("FAIL mid_fetch: got %h (done=%0d lat=%0d) expected %h lat 2", obs, got, cyc, exp);
        end
        if_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_simultaneous();
        test_priority();
        test_timeout();
        test_ack_at_limit();
        test_reset_mid();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-ported external memory between the pipeline's instruction-fetch port and its data (load/store) port. It serialises requests over a req/ack memory handshake and returns read data to the port that issued the request. While either port waits, it raises a stall so the pipeline holds its PC and pipeline registers. A bounded wait timer converts a hung memory access into an error pulse.

## Interface
Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte enables are DATA_W/8 bits.
- MAX_WAIT, 255, grant-state cycles allowed without i_m_ack before timeout; 0 disables the timeout.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_if_req  in  1  fetch request, level; held until o_if_valid.
- i_if_addr  in  ADDR_W  fetch address; stable while i_if_req.
- o_if_rdata  out  DATA_W  fetched instruction; valid with o_if_valid.
- o_if_valid  out  1  one-cycle completion pulse.
- i_d_req  in  1  data request, level; held until o_d_valid.
- i_d_we  in  1  1 = store, 0 = load.
- i_d_addr  in  ADDR_W  data address.
- i_d_wdata  in  DATA_W  store data.
- i_d_be  in  DATA_W/8  store byte enables.
- o_d_rdata  out  DATA_W  load data; valid with o_d_valid.
- o_d_valid  out  1  one-cycle completion pulse, for loads and stores.
- o_m_req  out  1  memory request; held until i_m_ack.
- o_m_we, o_m_addr, o_m_wdata, o_m_be  out  1/ADDR_W/DATA_W/DATA_W/8  latched command.
- i_m_ack  in  1  one-cycle completion from memory.
- i_m_rdata  in  DATA_W  read data; valid in the i_m_ack cycle.
- o_stall  out  1  combinational: (i_if_req & ~o_if_valid) | (i_d_req & ~o_d_valid).
- o_err  out  1  one-cycle pulse on timeout, coincident with the valid pulse.

## Operation
- FSM states: IDLE, GNT_IF, GNT_D, DONE.
- IDLE:
  - If i_d_req is high: latch the data command and go to GNT_D.
  - Else if i_if_req is high: latch the fetch address (we = 0, be = all ones) and go to GNT_IF.
  - Default arbitration priority is data over fetch.
- GNT_IF / GNT_D:
  - o_m_req = 1; o_m_* are driven from the latched command and stay stable throughout.
  - On i_m_ack: register i_m_rdata into the granted port's rdata register (a store registers 0) and go to DONE.
- DONE:
  - The granted port's valid is high for exactly this cycle.
  - Requests are ignored in DONE; next state is IDLE. This lets the requester drop or change its request without a spurious reissue.
- Wait counter:
  - Width $clog2(MAX_WAIT+1).
  - Cleared on entry to a grant state; increments each grant cycle without ack.
  - When it reaches MAX_WAIT (and MAX_WAIT ≠ 0): drop o_m_req, load rdata = 0, pulse o_err in the DONE cycle.
  - If i_m_ack arrives in the same cycle the counter reaches MAX_WAIT, the ack wins and there is no error.
- Request changes: a request withdrawn after being granted still completes; the valid pulse is ignored by the requester.
- Reset (also mid-operation): next edge enters IDLE; o_m_req, o_m_*, o_*_valid, o_*_rdata and o_err all go to 0; the counter clears. The memory side must tolerate a dropped request.

## Timing
- Zero-wait memory (ack in the first grant cycle):
  - Request sampled at edge 0.
  - o_m_req high in cycle 1, ack in cycle 1.
  - Valid in cycle 2; IDLE in cycle 3.
  - Minimum issue interval is 3 cycles.
- N wait cycles add N cycles of latency.
- Both ports requesting together: the data access completes first; the fetch is granted in the IDLE cycle after DONE.
- All outputs except o_stall are registered.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN:
  - Defined: when both ports request in IDLE, grant the port not granted last. A 1-bit last-grant register resets to "fetch", so data wins the first tie.
  - Undefined: fixed data-over-fetch priority, and the last-grant register is not built.

## Structure
- Package mem_arb_pkg holds:
  - the arb_state_t enum (IDLE, GNT_IF, GNT_D, DONE);
  - the port-select encoding (PORT_IF = 0, PORT_D = 1).
- Sub-module mem_arb_wait_timer (parameter MAX_WAIT) holds the counter. Inputs: clear, enable, ack. Output: timeout.

## Test plan
- Fetch only, ack in the first grant cycle, i_m_rdata=0x00500093 -> o_m_req high 1 cycle, o_if_valid 2 cycles after request with o_if_rdata=0x00500093, o_stall low after valid.
- Simultaneous i_if_req/i_d_req (store, addr 0x100, be 0x3, 2-cycle ack delay) -> store issued first with o_m_be=0x3, o_d_valid, then fetch issued; o_stall stays high throughout.
- Round-robin build, both ports requesting continuously with zero-wait ack -> grants alternate D, IF, D, IF; fixed-priority build -> D every time while i_d_req held.
- MAX_WAIT=4, memory never acks -> o_m_req high exactly 4 cycles, then o_err and o_d_valid pulse together with o_d_rdata=0, FSM back in IDLE.
- i_m_ack in the same cycle the counter reaches MAX_WAIT -> normal completion with real data, o_err stays 0.
- i_reset asserted for one cycle while in GNT_D -> o_m_req and all valids 0 on the next edge; a fresh fetch afterwards completes normally.
